ahbl_master_port: RTL and testbench
===================================

// Module: ahbl_master_port
// PURPOSE
// - AHB-Lite initiator: turns single-word commands (valid/ready) into AHB-Lite SINGLE transfers
//   and returns one in-order response per command. Drives the bus side of the register slaves.
// - Pipelined: next address phase overlaps current data phase; handles wait states and 2-cycle ERROR.
// PARAMETERS
// - ADDR_W  32  address width (HADDR, cmd_addr)
// - DATA_W  32  data width (HWDATA, HRDATA, cmd_wdata, rsp_rdata); word transfers only
// PORTS
// - HCLK       in   1       bus clock; all logic on posedge
// - HRESETn    in   1       reset, asynchronous, active-low
// - cmd_valid  in   1       command present
// - cmd_ready  out  1       command accepted at posedge when cmd_valid&cmd_ready
// - cmd_write  in   1       1=write, 0=read
// - cmd_addr   in   ADDR_W  byte address; bits [1:0] ignored
// - cmd_wdata  in   DATA_W  write data (captured at accept)
// - rsp_valid  out  1       1-cycle pulse: one command retired
// - rsp_write  out  1       direction of retired command
// - rsp_err    out  1       1=ERROR from slave or transfer cancelled
// - rsp_rdata  out  DATA_W  read data (0 for writes/errors)
// - busy       out  1       any address or data phase outstanding
// - HADDR      out  ADDR_W  HADDR[1:0]=2'b00
// - HTRANS     out  2       IDLE=2'b00 / NONSEQ=2'b10 only
// - HWRITE     out  1
// - HSIZE      out  3       constant 3'b010
// - HBURST     out  3       constant 3'b000 (SINGLE)
// - HWDATA     out  DATA_W  valid throughout data phase
// - HREADY     in   1       bus ready (mux of HREADYOUT)
// - HRESP      in   1       0=OKAY, 1=ERROR
// - HRDATA     in   DATA_W
// BEHAVIOUR
// - Reset: HTRANS=IDLE, HADDR/HWRITE/HWDATA=0, rsp_valid=rsp_err=rsp_write=0, rsp_rdata=0, busy=0.
//   Mid-operation reset drops all outstanding commands; no responses emitted for them.
// - State: addr slot (a_vld,addr,write,wdata) and data slot (d_vld,write,wdata); registered outputs.
// - cmd_ready = ~a_vld | (HREADY & ~err1), err1 = d_vld & HRESP & ~HREADY (combinational).
// - Accept at edge E0 -> HTRANS=NONSEQ, HADDR/HWRITE driven from E0; held stable until HREADY=1.
// - Address phase completes at first edge with HREADY=1: slot moves to data slot; HWDATA driven
//   from that edge for writes, held until data phase completes. If no new command accepted at the
//   same edge, HTRANS=IDLE next cycle.
// - Data phase completes at edge with HREADY=1; rsp_valid pulses the following cycle, rsp_rdata =
//   HRDATA sampled at that edge, rsp_err = HRESP sampled. Zero-wait latency: accept E0 -> rsp_valid
//   high in cycle E2..E3. Each wait state adds 1 cycle. Back-to-back: 1 command/cycle with no waits.
// - ERROR: on err1 cycle, if a_vld, drive HTRANS=IDLE from next edge (cancel); cancelled command
//   retires with rsp_err=1 in the cycle after the erroring one's response (order preserved), never
//   issued on bus. Erroring transfer retires with rsp_err=1.
// - HRESP=1 with no data phase outstanding: ignored. Responses strictly in command order.
// - busy = a_vld | d_vld | pending cancelled response.
// STRUCTURE
// - Package ahbl_pkg: HTRANS_IDLE/NONSEQ, HSIZE_WORD, HBURST_SINGLE, HRESP_OKAY/ERROR localparams.
// - No sub-module: two slot registers plus small response register; one file.
// TESTING (bench pairs DUT with AHB-Lite register slave model, configurable wait states/ERROR)
// - Write 0xDEADBEEF @0x0100_0000, 0 waits -> NONSEQ 1 cycle, HWDATA=0xDEADBEEF next cycle,
//   rsp_valid 2 cycles after accept, rsp_err=0.
// - Read back @0x0100_0000 with slave 1 wait state -> HADDR held, rsp_rdata=0xDEADBEEF 3 cycles
//   after accept.
// - 3 back-to-back writes @0x0000_0000/0x0100_0000/0x0200_0000, cmd_valid held -> cmd_ready
//   stays 1, 3 consecutive rsp_valid pulses, slave regs 0..2 match.
// - Read with HRESP ERROR while next write queued -> HTRANS=IDLE after first error cycle, two
//   responses both rsp_err=1, slave register unchanged.
// - Assert HRESETn=0 during wait state -> HTRANS=IDLE, busy=0 immediately; no rsp_valid after.
// - cmd_addr=0x0000_0103 -> HADDR=0x0000_0100; HSIZE=3'b010, HBURST=3'b000 always.

Source files
------------

// File: rtl/ahbl_pkg.sv
// rtl/ahbl_pkg.sv - AHB-Lite encodings shared by the master port and its users
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

endpackage

// File: rtl/ahbl_master_port.sv
// rtl/ahbl_master_port.sv - AHB-Lite initiator issuing SINGLE word transfers from a cmd stream
// Address slot overlaps the data slot; a cancelled address-phase command retires after the erroring one.
module ahbl_master_port
  import ahbl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  input  logic [DATA_W-1:0] HRDATA
);

  logic              a_vld;
  logic              a_write;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              d_vld;
  logic              d_write;
  logic [DATA_W-1:0] d_wdata;
  logic              c_pend;
  logic              c_write;

  logic err1;
  logic accept;
  logic addr_done;
  logic data_done;
  logic cancel;
  logic c_retire;

  // First ERROR cycle: slave holds HREADY low with HRESP high
  assign err1      = d_vld & (HRESP == HRESP_ERROR) & ~HREADY;
  assign cmd_ready = ~a_vld | (HREADY & ~err1);
  assign accept    = cmd_valid & cmd_ready;
  assign addr_done = a_vld & HREADY;
  assign data_done = d_vld & HREADY;
  assign cancel    = err1 & a_vld;
  // Cancelled command waits until the erroring transfer has left the data slot
  assign c_retire  = c_pend & ~d_vld;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      a_vld     <= 1'b0;
      a_write   <= 1'b0;
      a_addr    <= '0;
      a_wdata   <= '0;
      d_vld     <= 1'b0;
      d_write   <= 1'b0;
      d_wdata   <= '0;
      c_pend    <= 1'b0;
      c_write   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        a_vld   <= 1'b1;
        a_write <= cmd_write;
        a_addr  <= {cmd_addr[ADDR_W-1:2], 2'b00};
        a_wdata <= cmd_wdata;
      end else if (addr_done || cancel) begin
        a_vld <= 1'b0;
      end

      if (addr_done) begin
        d_vld   <= 1'b1;
        d_write <= a_write;
        if (a_write) begin
          d_wdata <= a_wdata;
        end
      end else if (data_done) begin
        d_vld <= 1'b0;
      end

      if (cancel) begin
        c_pend  <= 1'b1;
        c_write <= a_write;
      end else if (c_retire) begin
        c_pend <= 1'b0;
      end

      rsp_valid <= 1'b0;
      if (data_done) begin
        rsp_valid <= 1'b1;
        rsp_write <= d_write;
        rsp_err   <= (HRESP == HRESP_ERROR);
        rsp_rdata <= (d_write || (HRESP == HRESP_ERROR)) ? '0 : HRDATA;
      end else if (c_retire) begin
        rsp_valid <= 1'b1;
        rsp_write <= c_write;
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end
    end
  end

  assign HTRANS = a_vld ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR  = a_addr;
  assign HWRITE = a_write;
  assign HWDATA = d_wdata;
  assign HSIZE  = HSIZE_WORD;
  assign HBURST = HBURST_SINGLE;
  assign busy   = a_vld | d_vld | c_pend;

endmodule

// File: tb/tb_ahbl_master_port.sv
// tb/tb_ahbl_master_port.sv - directed bench for ahbl_master_port with a register slave model
module tb_ahbl_master_port;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_write;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HRESP;
  logic [31:0] HRDATA;

  ahbl_master_port #(.ADDR_W(32), .DATA_W(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .busy(busy),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  // Register slave model: 16 words indexed by HADDR[27:24]
  int          cfg_waits = 0;
  logic        cfg_err_en = 1'b0;
  logic [31:0] cfg_err_addr = '0;
  logic [31:0] mem [16];
  logic        s_act, s_write, s_err, s_errph, wr3_seen;
  logic [31:0] s_addr;
  int          s_cnt;

  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = '0;
    if (s_act) begin
      if (s_cnt != 0) HREADY = 1'b0;
      else if (s_err) begin
        HRESP  = 1'b1;
        HREADY = s_errph;
      end
      if (!s_write && !s_err) HRDATA = mem[s_addr[27:24]];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      s_act <= 1'b0; s_write <= 1'b0; s_err <= 1'b0; s_errph <= 1'b0;
      s_addr <= '0; s_cnt <= 0; wr3_seen <= 1'b0;
      for (int k = 0; k < 16; k++) mem[k] <= '0;
    end else begin
      if (s_act) begin
        if (s_cnt != 0) s_cnt <= s_cnt - 1;
        else if (s_err && !s_errph) s_errph <= 1'b1;
        else begin
          if (s_write && !s_err) mem[s_addr[27:24]] <= HWDATA;
          s_act <= 1'b0;
        end
      end
      if (HREADY && HTRANS == 2'b10) begin
        s_act   <= 1'b1;
        s_addr  <= HADDR;
        s_write <= HWRITE;
        s_cnt   <= cfg_waits;
        s_err   <= cfg_err_en && (HADDR == cfg_err_addr);
        s_errph <= 1'b0;
        if (HADDR == 32'h0300_0000) wr3_seen <= 1'b1;
      end
    end
  end

  typedef struct {
    logic        w;
    logic        e;
    logic [31:0] d;
    int          c;
  } rsp_t;
  rsp_t rq[$];

  always @(negedge HCLK) begin
    if (HRESETn && rsp_valid) rq.push_back('{rsp_write, rsp_err, rsp_rdata, cyc});
  end

  logic const_bad = 1'b0;
  always @(negedge HCLK) begin
    if (HSIZE !== 3'b010 || HBURST !== 3'b000) const_bad <= 1'b1;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, output int acc);
    int n = 0;
    @(negedge HCLK);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 50) begin
      @(negedge HCLK);
      n++;
    end
    check("cmd_ready_at_send", 32'(cmd_ready), 32'd1);
    acc = cyc + 1;
    @(posedge HCLK);
  endtask

  task automatic get_rsp(output rsp_t r);
    int n = 0;
    r = '{1'b0, 1'b0, 32'h0, 0};
    while (rq.size() == 0 && n < 40) begin
      @(posedge HCLK);
      n++;
    end
    check("rsp_arrived", 32'(rq.size() > 0), 32'd1);
    if (rq.size() > 0) r = rq.pop_front();
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic        err_en;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;
  vec_t vecs[8];

  initial begin
    rsp_t r, r1, r2, r3;
    int acc, acc2;

    vecs[0] = '{1'b1, 32'h0100_0000, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, 32'h0,          2};
    vecs[1] = '{1'b0, 32'h0100_0000, 32'h0,         1, 1'b0, 1'b0, 32'hDEAD_BEEF, 3};
    vecs[2] = '{1'b1, 32'h0500_0000, 32'h1234_5678, 2, 1'b0, 1'b0, 32'h0,          4};
    vecs[3] = '{1'b0, 32'h0500_0000, 32'h0,         0, 1'b0, 1'b0, 32'h1234_5678, 2};
    vecs[4] = '{1'b0, 32'h0600_0000, 32'h0,         0, 1'b1, 1'b1, 32'h0,          3};
    vecs[5] = '{1'b1, 32'h0600_0000, 32'hCAFE_F00D, 0, 1'b1, 1'b1, 32'h0,          3};
    vecs[6] = '{1'b0, 32'h0600_0000, 32'h0,         0, 1'b0, 1'b0, 32'h0,          2};
    vecs[7] = '{1'b1, 32'h0000_0103, 32'hA5A5_0001, 0, 1'b0, 1'b0, 32'h0,          2};

    repeat (3) @(negedge HCLK);
    check("rst_htrans", 32'(HTRANS), 32'd0);
    check("rst_haddr", HADDR, 32'h0);
    check("rst_hwrite", 32'(HWRITE), 32'd0);
    check("rst_hwdata", HWDATA, 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    HRESETn = 1'b1;
    @(negedge HCLK);
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      cfg_waits = vecs[i].waits;
      cfg_err_en = vecs[i].err_en;
      cfg_err_addr = vecs[i].addr & 32'hFFFF_FFFC;
      rq.delete();
      send(vecs[i].wr, vecs[i].addr, vecs[i].wdata, acc);
      @(negedge HCLK);
      cmd_valid = 1'b0;
      check($sformatf("v%0d_htrans_nonseq", i), 32'(HTRANS), 32'd2);
      check($sformatf("v%0d_haddr", i), HADDR, vecs[i].addr & 32'hFFFF_FFFC);
      check($sformatf("v%0d_hwrite", i), 32'(HWRITE), 32'(vecs[i].wr));
      @(negedge HCLK);
      check($sformatf("v%0d_htrans_idle", i), 32'(HTRANS), 32'd0);
      if (vecs[i].wr) check($sformatf("v%0d_hwdata", i), HWDATA, vecs[i].wdata);
      get_rsp(r);
      check($sformatf("v%0d_rsp_err", i), 32'(r.e), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_rsp_write", i), 32'(r.w), 32'(vecs[i].wr));
      check($sformatf("v%0d_rsp_rdata", i), r.d, vecs[i].exp_rdata);
      check($sformatf("v%0d_latency", i), 32'(r.c - acc), 32'(vecs[i].exp_lat));
    end
    cfg_err_en = 1'b0;
    cfg_waits = 0;

    // Back-to-back writes with cmd_valid held
    rq.delete();
    send(1'b1, 32'h0000_0000, 32'h1111_1111, acc);
    send(1'b1, 32'h0100_0000, 32'h2222_2222, acc2);
    check("b2b_accept_gap", 32'(acc2 - acc), 32'd1);
    send(1'b1, 32'h0200_0000, 32'h3333_3333, acc2);
    @(negedge HCLK);
    cmd_valid = 1'b0;
    get_rsp(r1);
    get_rsp(r2);
    get_rsp(r3);
    check("b2b_lat0", 32'(r1.c - acc), 32'd2);
    check("b2b_consec1", 32'(r2.c - r1.c), 32'd1);
    check("b2b_consec2", 32'(r3.c - r1.c), 32'd2);
    check("b2b_err", 32'({r1.e, r2.e, r3.e}), 32'd0);
    check("b2b_mem0", mem[0], 32'h1111_1111);
    check("b2b_mem1", mem[1], 32'h2222_2222);
    check("b2b_mem2", mem[2], 32'h3333_3333);

    // ERROR on a read while a write sits in the address phase
    repeat (2) @(negedge HCLK);
    rq.delete();
    cfg_err_en = 1'b1;
    cfg_err_addr = 32'h0600_0000;
    send(1'b0, 32'h0600_0000, 32'h0, acc);
    send(1'b1, 32'h0300_0000, 32'h7777_7777, acc2);
    @(negedge HCLK);
    cmd_valid = 1'b0;
    check("err1_cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge HCLK);
    check("err_cancel_htrans", 32'(HTRANS), 32'd0);
    check("err_busy", 32'(busy), 32'd1);
    get_rsp(r1);
    get_rsp(r2);
    check("err_rsp1_err", 32'(r1.e), 32'd1);
    check("err_rsp1_write", 32'(r1.w), 32'd0);
    check("err_rsp1_rdata", r1.d, 32'h0);
    check("err_rsp2_err", 32'(r2.e), 32'd1);
    check("err_rsp2_write", 32'(r2.w), 32'd1);
    check("err_rsp_order", 32'(r2.c - r1.c), 32'd1);
    check("err_never_issued", 32'(wr3_seen), 32'd0);
    check("err_mem3", mem[3], 32'h0);
    @(negedge HCLK);
    check("err_busy_clear", 32'(busy), 32'd0);
    cfg_err_en = 1'b0;

    // Reset asserted while the slave is inserting wait states
    cfg_waits = 3;
    rq.delete();
    send(1'b0, 32'h0100_0000, 32'h0, acc);
    @(negedge HCLK);
    cmd_valid = 1'b0;
    @(negedge HCLK);
    check("wait_busy", 32'(busy), 32'd1);
    HRESETn = 1'b0;
    #1;
    check("rst_mid_htrans", 32'(HTRANS), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    cfg_waits = 0;
    repeat (10) @(negedge HCLK);
    check("rst_no_rsp", 32'(rq.size()), 32'd0);
    check("rst_busy_after", 32'(busy), 32'd0);
    check("hsize_hburst_const", 32'(const_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
